// File: rtl/tdm_pkg.sv
// Shared constants and FSM state encoding for the 8-slot TDM demultiplexer.
package tdm_pkg;

  localparam int unsigned SLOTS = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned ERR_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t HUNT = 2'd0;
  localparam state_t ACQ  = 2'd1;
  localparam state_t LOCK = 2'd2;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot index counter: wraps at the top slot, with clear-to-0 and load-to-1 controls.
module tdm_slot_cnt
  import tdm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             load1_i,
  input  logic             clr_i,
  output logic [SEL_W-1:0] cnt_o
);

  logic [SEL_W-1:0] cnt_d, cnt_q;

  // Clear dominates load, load dominates increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = SEL_W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tdm_demux8.sv
// 8-slot serial TDM demultiplexer with HUNT/ACQ/LOCK frame alignment.
// Define TDM_DEMUX_ERRCNT_EN to add a saturating sync-error counter on port err_cnt.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             sync,
  output logic [SLOTS-1:0] Y,
  output logic             valid,
  output logic [SEL_W-1:0] sel,
  output logic             locked,
  output logic             sync_err
`ifdef TDM_DEMUX_ERRCNT_EN
  ,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  localparam logic [SEL_W-1:0] LastSlot = SEL_W'(SLOTS - 1);

  state_t           state_d, state_q;
  logic [SLOTS-2:0] shadow_d, shadow_q;
  logic [3:0]       good_d, good_q;
  logic [3:0]       good_inc;
  logic [SLOTS-1:0] y_d, y_q;
  logic             valid_d, valid_q;
  logic             err_d, err_q;
  logic             cnt_inc, cnt_load1, cnt_clr;
  logic [SEL_W-1:0] sel_q;

  tdm_slot_cnt u_slot_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (cnt_inc),
    .load1_i (cnt_load1),
    .clr_i   (cnt_clr),
    .cnt_o   (sel_q)
  );

  assign good_inc = good_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    good_d    = good_q;
    y_d       = y_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    cnt_inc   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_clr   = 1'b0;
    if (en) begin
      if (state_q == HUNT) begin
        if (sync) begin
          shadow_d[0] = din;
          cnt_load1   = 1'b1;
          good_d      = '0;
          state_d     = ACQ;
        end
      end else if (sync && (sel_q != '0)) begin
        // Early marker: treat this slot as slot 0 of a fresh frame.
        err_d       = 1'b1;
        shadow_d[0] = din;
        cnt_load1   = 1'b1;
        good_d      = '0;
        state_d     = ACQ;
      end else if (!sync && (sel_q == '0)) begin
        err_d   = 1'b1;
        cnt_clr = 1'b1;
        state_d = HUNT;
      end else begin
        cnt_inc = 1'b1;
        if (sel_q != LastSlot) begin
          shadow_d[sel_q] = din;
        end else if (state_q == ACQ) begin
          good_d = good_inc;
          if (good_inc == 4'(LOCK_FRAMES)) begin
            state_d = LOCK;
          end
        end else if (state_q == LOCK) begin
          // Slot 7 bypasses the shadow so the frame lands on this edge.
          y_d     = {din, shadow_q};
          valid_d = 1'b1;
        end else begin
          state_d = HUNT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      good_q   <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      good_q   <= good_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

`ifdef TDM_DEMUX_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_d, err_cnt_q;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign Y        = y_q;
  assign valid    = valid_q;
  assign sel      = sel_q;
  assign locked   = (state_q == LOCK);
  assign sync_err = err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Scoreboard bench for tdm_demux8; also checks err_cnt when TDM_DEMUX_ERRCNT_EN is defined.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       sync = 1'b0;
  logic [7:0] Y;
  logic       valid;
  logic [2:0] sel;
  logic       locked;
  logic       sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [3:0] err_cnt;
`endif

  int         checks = 0;
  int         errors = 0;
  int         err_exp = 0;
  int         err_seen = 0;
  int         cyc = 0;
  int         gap = 0;
  logic [7:0] exp_q[$];
  int         vcyc[$];
  logic [7:0] mon_e;

  tdm_demux8 #(
    .LOCK_FRAMES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din),
    .sync     (sync),
    .Y        (Y),
    .valid    (valid),
    .sel      (sel),
    .locked   (locked),
    .sync_err (sync_err)
`ifdef TDM_DEMUX_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: every valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        checks++;
        vcyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL valid_unexpected got Y=%h with no frame expected", Y);
        end else begin
          mon_e = exp_q.pop_front();
          if (Y !== mon_e) begin
            errors++;
            $display("FAIL y_frame got %h want %h", Y, mon_e);
          end
        end
      end
      if (sync_err) err_seen++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic slot(input logic d, input logic s);
    en   = 1'b1;
    din  = d;
    sync = s;
    @(posedge clk);
    #1;
    en   = 1'b0;
    din  = 1'b0;
    sync = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) slot(v[i], (i == 0));
  endtask

  task automatic frame(input logic [7:0] v);
    send(v, 0, 7);
  endtask

  initial begin
    #12;
    chk("rst_y", Y, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_sel", sel, 0);
    chk("rst_locked", locked, 0);
    chk("rst_sync_err", sync_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // HUNT ignores unsynchronised slots.
    slot(1'b1, 1'b0);
    slot(1'b0, 1'b0);
    chk("hunt_sel", sel, 0);
    chk("hunt_no_err", sync_err, 0);

    frame(8'hA5);
    chk("acq_f1_unlocked", locked, 0);
    frame(8'hA5);
    chk("acq_f2_locked", locked, 1);
    chk("acq_f2_no_valid", valid, 0);
    exp_q.push_back(8'hA5);
    frame(8'hA5);
    chk("lock_f3_y", Y, 8'hA5);
    chk("lock_f3_valid", valid, 1);
    @(posedge clk);
    #1;
    chk("valid_one_cycle", valid, 0);

    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    frame(8'h3C);
    frame(8'hC3);
    chk("stream_y", Y, 8'hC3);
    @(negedge clk);
    #1;
    chk("stream_spacing", vcyc[vcyc.size()-1] - vcyc[vcyc.size()-2], 8);

    // Early sync at sel=5 restarts acquisition from that slot.
    send(8'h5A, 0, 4);
    chk("early_pre_sel", sel, 5);
    err_exp++;
    slot(1'b0, 1'b1);
    chk("early_err", sync_err, 1);
    chk("early_unlocked", locked, 0);
    chk("early_sel", sel, 1);
    chk("early_y_hold", Y, 8'hC3);
    send(8'hF0, 1, 7);
    chk("early_reacq1", locked, 0);
    chk("early_no_err", sync_err, 0);
    frame(8'h0F);
    chk("early_relock", locked, 1);
    exp_q.push_back(8'h96);
    frame(8'h96);
    chk("early_deliver_y", Y, 8'h96);

    // Missing sync at slot 0 drops to HUNT.
    err_exp++;
    slot(1'b1, 1'b0);
    chk("miss_err", sync_err, 1);
    chk("miss_unlocked", locked, 0);
    chk("miss_sel", sel, 0);
    repeat (3) slot(1'b1, 1'b0);
    chk("miss_hunt_sel", sel, 0);
    chk("miss_hunt_no_err", sync_err, 0);
    chk("miss_y_hold", Y, 8'h96);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("errcnt_two", err_cnt, 2);
`endif

    slot(1'b1, 1'b1);
    chk("resync_sel", sel, 1);
    for (int i = 0; i < 20; i++) begin
      err_exp++;
      slot(1'b0, 1'b1);
    end
    chk("burst_err", sync_err, 1);
    chk("burst_sel", sel, 1);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("errcnt_sat", err_cnt, 4'hF);
`endif
    @(negedge clk);
    #1;
    chk("err_pulse_count", err_seen, err_exp);

    rst_n = 1'b0;
    #1;
    chk("rst2_sel", sel, 0);
    chk("rst2_y", Y, 8'h00);
`ifdef TDM_DEMUX_ERRCNT_EN
    chk("rst2_errcnt", err_cnt, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Gapped strobe: one en every third cycle.
    gap = 2;
    frame(8'hA5);
    frame(8'hA5);
    chk("gap_locked", locked, 1);
    chk("gap_y_before", Y, 8'h00);
    exp_q.push_back(8'hA5);
    frame(8'hA5);
    chk("gap_y", Y, 8'hA5);

    send(8'h3C, 0, 3);
    chk("midrst_pre_sel", sel, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_y", Y, 8'h00);
    chk("midrst_valid", valid, 0);
    chk("midrst_sel", sel, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_sync_err", sync_err, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    gap = 0;
    slot(1'b1, 1'b0);
    chk("postrst_hunt_sel", sel, 0);
    frame(8'h81);
    chk("postrst_acq", locked, 0);
    frame(8'h81);
    chk("postrst_lock", locked, 1);
    exp_q.push_back(8'h81);
    frame(8'h81);
    chk("postrst_y", Y, 8'h81);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("err_pulse_total", err_seen, err_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
